// File: rtl/axi_master_engine.sv
// Single-outstanding AXI initiator: takes one read or write burst command from a local
// user port, runs the AW/W/B or AR/R sequence, and pulses done with the final response.
module axi_master_engine #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic                  i_aclk,
  input  logic                  i_areset,
  // user command port
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_write,
  input  logic [ADDR_W-1:0]     i_cmd_addr,
  input  logic [LEN_W-1:0]      i_cmd_len,
  input  logic [1:0]            i_cmd_burst,
  // user write-beat stream
  input  logic [DATA_W-1:0]     i_wr_data,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  // user read-beat stream
  output logic [DATA_W-1:0]     o_rd_data,
  output logic                  o_rd_last,
  output logic                  o_rd_valid,
  input  logic                  i_rd_ready,
  // status
  output logic                  o_done,
  output logic [1:0]            o_done_resp,
  output logic                  o_busy,
  // AXI write address channel
  output logic [ADDR_W-1:0]     o_awaddr,
  output logic [LEN_W-1:0]      o_awlen,
  output logic [2:0]            o_awsize,
  output logic [1:0]            o_awburst,
  output logic                  o_awvalid,
  input  logic                  i_awready,
  // AXI write data channel
  output logic [DATA_W-1:0]     o_wdata,
  output logic [DATA_W/8-1:0]   o_wstrb,
  output logic                  o_wlast,
  output logic                  o_wvalid,
  input  logic                  i_wready,
  // AXI write response channel
  input  logic [1:0]            i_bresp,
  input  logic                  i_bvalid,
  output logic                  o_bready,
  // AXI read address channel
  output logic [ADDR_W-1:0]     o_araddr,
  output logic [LEN_W-1:0]      o_arlen,
  output logic [2:0]            o_arsize,
  output logic [1:0]            o_arburst,
  output logic                  o_arvalid,
  input  logic                  i_arready,
  // AXI read data channel
  input  logic [DATA_W-1:0]     i_rdata,
  input  logic [1:0]            i_rresp,
  input  logic                  i_rlast,
  input  logic                  i_rvalid,
  output logic                  o_rready
);

  // state  | meaning
  // IDLE   | waiting for a command, cmd_ready high
  // WADDR  | awvalid high until the AW handshake
  // WDATA  | user write beats passed straight through to W
  // WRESP  | bready high until the B handshake
  // RADDR  | arvalid high until the AR handshake
  // RDATA  | R beats passed straight through to the user read stream
  typedef enum logic [2:0] {
    S_IDLE,
    S_WADDR,
    S_WDATA,
    S_WRESP,
    S_RADDR,
    S_RDATA
  } state_t;

  localparam logic [2:0] AXSIZE = 3'($clog2(DATA_W / 8));
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [LEN_W-1:0]    r_len;
  logic [1:0]          r_burst;
  // One bit wider than len so a maximum-length burst cannot wrap before its last beat.
  logic [LEN_W:0]      r_beat_cnt;
  logic                r_cmd_ready;
  logic                r_busy;
  logic                r_awvalid;
  logic                r_arvalid;
  logic                r_bready;
  logic                r_done;
  logic [1:0]          r_done_resp;
  logic [1:0]          r_worst_resp;
  logic                r_last_err;

  logic                w_is_last;
  logic                w_in_wdata;
  logic                w_in_rdata;
  logic                w_w_hs;
  logic                w_r_hs;
  logic                w_rlast_bad;
  logic [1:0]          w_worst_next;
  logic [LEN_W:0]      w_beat_inc;

  assign w_is_last    = (r_beat_cnt == {1'b0, r_len});
  assign w_in_wdata   = (r_state == S_WDATA);
  assign w_in_rdata   = (r_state == S_RDATA);
  assign w_w_hs       = w_in_wdata && i_wr_valid && i_wready;
  assign w_r_hs       = w_in_rdata && i_rvalid && i_rd_ready;
  assign w_rlast_bad  = (i_rlast != w_is_last);
  assign w_worst_next = (i_rresp > r_worst_resp) ? i_rresp : r_worst_resp;
  assign w_beat_inc   = r_beat_cnt + {{LEN_W{1'b0}}, 1'b1};

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_len        <= '0;
      r_burst      <= '0;
      r_beat_cnt   <= '0;
      r_cmd_ready  <= 1'b1;
      r_busy       <= 1'b0;
      r_awvalid    <= 1'b0;
      r_arvalid    <= 1'b0;
      r_bready     <= 1'b0;
      r_done       <= 1'b0;
      r_done_resp  <= '0;
      r_worst_resp <= '0;
      r_last_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_cmd_valid) begin
            r_addr       <= i_cmd_addr;
            r_len        <= i_cmd_len;
            r_burst      <= i_cmd_burst;
            r_beat_cnt   <= '0;
            r_worst_resp <= '0;
            r_last_err   <= 1'b0;
            r_cmd_ready  <= 1'b0;
            r_busy       <= 1'b1;
            if (i_cmd_write) begin
              r_awvalid <= 1'b1;
              r_state   <= S_WADDR;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= S_RADDR;
            end
          end
        end

        S_WADDR: begin
          if (i_awready) begin
            r_awvalid <= 1'b0;
            r_state   <= S_WDATA;
          end
        end

        S_WDATA: begin
          if (w_w_hs) begin
            r_beat_cnt <= w_beat_inc;
            if (w_is_last) begin
              r_bready <= 1'b1;
              r_state  <= S_WRESP;
            end
          end
        end

        S_WRESP: begin
          if (i_bvalid) begin
            r_bready    <= 1'b0;
            r_done_resp <= i_bresp;
            r_done      <= 1'b1;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        S_RADDR: begin
          if (i_arready) begin
            r_arvalid <= 1'b0;
            r_state   <= S_RDATA;
          end
        end

        S_RDATA: begin
          if (w_r_hs) begin
            r_beat_cnt   <= w_beat_inc;
            r_worst_resp <= w_worst_next;
            r_last_err   <= r_last_err | w_rlast_bad;
            // Completion is counted, not taken from rlast, so a bad rlast cannot hang us.
            if (w_is_last) begin
              r_done_resp <= (r_last_err | w_rlast_bad) ? RESP_SLVERR : w_worst_next;
              r_done      <= 1'b1;
              r_cmd_ready <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= S_IDLE;
            end
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_awvalid   <= 1'b0;
          r_arvalid   <= 1'b0;
          r_bready    <= 1'b0;
        end
      endcase
    end
  end

  assign o_cmd_ready = r_cmd_ready;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_done_resp = r_done_resp;

  assign o_awaddr  = r_addr;
  assign o_awlen   = r_len;
  assign o_awsize  = AXSIZE;
  assign o_awburst = r_burst;
  assign o_awvalid = r_awvalid;

  assign o_araddr  = r_addr;
  assign o_arlen   = r_len;
  assign o_arsize  = AXSIZE;
  assign o_arburst = r_burst;
  assign o_arvalid = r_arvalid;

  assign o_wdata    = i_wr_data;
  assign o_wstrb    = '1;
  assign o_wlast    = w_is_last;
  assign o_wvalid   = w_in_wdata && i_wr_valid;
  assign o_wr_ready = w_in_wdata && i_wready;
  assign o_bready   = r_bready;

  assign o_rd_data  = i_rdata;
  assign o_rd_last  = w_is_last;
  assign o_rd_valid = w_in_rdata && i_rvalid;
  assign o_rready   = w_in_rdata && i_rd_ready;

endmodule

// File: tb/tb_axi_master_engine.sv
// Scoreboard bench for axi_master_engine: directed commands push expected beats and
// responses; a monitor pops and compares whenever the DUT presents them.
module tb_axi_master_engine;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              i_cmd_valid, i_cmd_write;
  logic [31:0]       i_cmd_addr;
  logic [7:0]        i_cmd_len;
  logic [1:0]        i_cmd_burst;
  logic [31:0]       i_wr_data;
  logic              i_wr_valid, i_rd_ready;
  logic              o_cmd_ready, o_wr_ready, o_rd_last, o_rd_valid, o_done, o_busy;
  logic [31:0]       o_rd_data;
  logic [1:0]        o_done_resp;
  logic [31:0]       o_awaddr, o_araddr, o_wdata;
  logic [7:0]        o_awlen, o_arlen;
  logic [2:0]        o_awsize, o_arsize;
  logic [1:0]        o_awburst, o_arburst;
  logic [3:0]        o_wstrb;
  logic              o_awvalid, o_wlast, o_wvalid, o_bready, o_arvalid, o_rready;
  logic              i_awready, i_wready, i_bvalid, i_arready, i_rlast, i_rvalid;
  logic [1:0]        i_bresp, i_rresp;
  logic [31:0]       i_rdata;

  axi_master_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .i_aclk(clk), .i_areset(rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
    .i_cmd_addr(i_cmd_addr), .i_cmd_len(i_cmd_len), .i_cmd_burst(i_cmd_burst),
    .i_wr_data(i_wr_data), .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready),
    .o_rd_data(o_rd_data), .o_rd_last(o_rd_last), .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready),
    .o_done(o_done), .o_done_resp(o_done_resp), .o_busy(o_busy),
    .o_awaddr(o_awaddr), .o_awlen(o_awlen), .o_awsize(o_awsize), .o_awburst(o_awburst),
    .o_awvalid(o_awvalid), .i_awready(i_awready),
    .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wlast(o_wlast), .o_wvalid(o_wvalid), .i_wready(i_wready),
    .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready),
    .o_araddr(o_araddr), .o_arlen(o_arlen), .o_arsize(o_arsize), .o_arburst(o_arburst),
    .o_arvalid(o_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rlast(i_rlast), .i_rvalid(i_rvalid), .o_rready(o_rready)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=no_event", name);
  endtask

  // scoreboard queues: {last,data}, {burst,len,addr}, resp
  logic [32:0] exp_w[$];
  logic [32:0] exp_rd[$];
  logic [41:0] exp_aw[$];
  logic [41:0] exp_ar[$];
  logic [1:0]  exp_done[$];
  int          done_cnt = 0;
  int          aw_stall_cnt = 0;

  // ---------------- monitor ----------------
  logic [32:0] mon_e;
  logic [41:0] mon_a;
  logic [1:0]  mon_r;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (o_awvalid) begin
          check("wvalid_before_aw", {o_wvalid, o_wr_ready}, 64'd0);
          if (!i_awready) aw_stall_cnt++;
          else if (exp_aw.size() == 0) fail_now("aw_unexpected");
          else begin
            mon_a = exp_aw.pop_front();
            check("awaddr", o_awaddr, mon_a[31:0]);
            check("awlen", o_awlen, mon_a[39:32]);
            check("awburst", o_awburst, mon_a[41:40]);
            check("awsize", o_awsize, 64'd2);
          end
        end
        if (o_arvalid && i_arready) begin
          if (exp_ar.size() == 0) fail_now("ar_unexpected");
          else begin
            mon_a = exp_ar.pop_front();
            check("araddr", o_araddr, mon_a[31:0]);
            check("arlen", o_arlen, mon_a[39:32]);
            check("arburst", o_arburst, mon_a[41:40]);
            check("arsize", o_arsize, 64'd2);
          end
        end
        if (o_wvalid && i_wready) begin
          check("wstrb", o_wstrb, 64'hF);
          if (exp_w.size() == 0) fail_now("w_unexpected");
          else begin
            mon_e = exp_w.pop_front();
            check("wdata", o_wdata, mon_e[31:0]);
            check("wlast", o_wlast, mon_e[32]);
          end
        end
        if (o_rd_valid) begin
          if (exp_rd.size() == 0) fail_now("rd_unexpected");
          else if (i_rd_ready) begin
            mon_e = exp_rd.pop_front();
            check("rd_data", o_rd_data, mon_e[31:0]);
            check("rd_last", o_rd_last, mon_e[32]);
          end else begin
            check("rd_stall_data", o_rd_data, exp_rd[0][31:0]);
            check("rd_stall_last", o_rd_last, exp_rd[0][32]);
          end
        end
        if (o_done) begin
          done_cnt++;
          check("done_busy", o_busy, 64'd0);
          check("done_cmd_ready", o_cmd_ready, 64'd1);
          if (exp_done.size() == 0) fail_now("done_unexpected");
          else begin
            mon_r = exp_done.pop_front();
            check("done_resp", o_done_resp, mon_r);
          end
        end
      end
    end
  end

  // ---------------- AXI slave model (word-indexed memory) ----------------
  logic [31:0] mem [0:255];
  int          aw_delay = 0;
  int          rlast_force = -1;
  int          rresp_beat = -1;
  logic [1:0]  rresp_val = 2'b00;
  logic [1:0]  bresp_val = 2'b00;
  logic [7:0]  wr_ptr, rd_ptr;
  int          rd_beat, rd_len, rlast_at, aw_cnt;
  bit          b_pend, r_active;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    for (int i = 0; i < 8; i++) mem[8'h10 + i] = 32'hA0 + i;
    i_awready = 0; i_wready = 0; i_bvalid = 0; i_bresp = 0; i_arready = 0;
    i_rvalid = 0; i_rdata = 0; i_rlast = 0; i_rresp = 0;
    wr_ptr = 0; rd_ptr = 0; rd_beat = 0; rd_len = 0; rlast_at = 0; aw_cnt = 0;
    b_pend = 0; r_active = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (o_awvalid && i_awready) wr_ptr = o_awaddr[7:0];
        if (o_wvalid && i_wready) begin
          mem[wr_ptr] = o_wdata;
          wr_ptr++;
          if (o_wlast) b_pend = 1;
        end
        if (o_bready && i_bvalid) b_pend = 0;
        if (o_arvalid && i_arready) begin
          rd_ptr   = o_araddr[7:0];
          rd_len   = int'(o_arlen) + 1;
          rd_beat  = 0;
          rlast_at = (rlast_force >= 0) ? rlast_force : int'(o_arlen);
          r_active = 1;
        end
        if (o_rready && i_rvalid) begin
          rd_ptr++;
          rd_beat++;
          if (rd_beat == rd_len) r_active = 0;
        end
      end
      @(posedge clk);
      #1;
      if (rst) begin
        b_pend = 0; r_active = 0; aw_cnt = 0; rd_beat = 0;
        i_awready = 0; i_wready = 0; i_bvalid = 0; i_arready = 0; i_rvalid = 0; i_rlast = 0;
      end else begin
        if (o_awvalid) begin
          i_awready = (aw_cnt >= aw_delay);
          aw_cnt++;
        end else begin
          i_awready = 0;
          aw_cnt = 0;
        end
        i_arready = o_arvalid;
        i_wready  = 1;
        i_bvalid  = b_pend;
        i_bresp   = bresp_val;
        i_rvalid  = r_active;
        i_rdata   = mem[rd_ptr];
        i_rlast   = (rd_beat == rlast_at);
        i_rresp   = (rd_beat == rresp_beat) ? rresp_val : 2'b00;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [31:0] wbuf [0:7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input bit wr, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst);
    int t;
    i_cmd_valid = 1; i_cmd_write = wr; i_cmd_addr = addr; i_cmd_len = len; i_cmd_burst = burst;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!o_cmd_ready && t < 50);
    if (!o_cmd_ready) fail_now("cmd_accept_timeout");
    step();
    i_cmd_valid = 0;
  endtask

  task automatic send_w(input int n, input int pre);
    int t;
    repeat (pre) step();
    for (int i = 0; i < n; i++) begin
      i_wr_valid = 1;
      i_wr_data  = wbuf[i];
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!o_wr_ready && t < 50);
      if (!o_wr_ready) fail_now("wr_ready_timeout");
      step();
    end
    i_wr_valid = 0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_w.size() + exp_rd.size() + exp_done.size() + exp_aw.size() + exp_ar.size() != 0
            || o_busy) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) fail_now("completion_timeout");
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  // ---------------- directed tests ----------------
  int d0, s0;
  initial begin
    rst = 1;
    i_cmd_valid = 0; i_cmd_write = 0; i_cmd_addr = 0; i_cmd_len = 0; i_cmd_burst = 0;
    i_wr_data = 0; i_wr_valid = 0; i_rd_ready = 1;
    #2;
    check("rst_cmd_ready", o_cmd_ready, 64'd1);
    check("rst_busy", o_busy, 64'd0);
    check("rst_done", o_done, 64'd0);
    check("rst_done_resp", o_done_resp, 64'd0);
    check("rst_valids", {o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready, o_rd_valid, o_wr_ready}, 64'd0);
    check("rst_addr_len", {o_awaddr, o_awlen, o_awburst}, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 0;
    step();

    // 1: write len=3 INCR, 0x11..0x44
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = 32'h11 * (i + 1);
      exp_w.push_back({(i == 3), 32'h11 * (i + 1)});
    end
    exp_aw.push_back({2'b01, 8'd3, 32'h0});
    exp_done.push_back(2'b00);
    issue_cmd(1, 32'h0, 8'd3, 2'b01);
    send_w(4, 0);
    wait_idle();

    // 2: read back two of those words
    exp_ar.push_back({2'b01, 8'd1, 32'h2});
    exp_rd.push_back({1'b0, 32'h33});
    exp_rd.push_back({1'b1, 32'h44});
    exp_done.push_back(2'b00);
    issue_cmd(0, 32'h2, 8'd1, 2'b01);
    wait_idle();

    // 3: single-beat write, slow AW, late data, EXOKAY response
    aw_delay = 3;
    bresp_val = 2'b01;
    d0 = done_cnt;
    s0 = aw_stall_cnt;
    wbuf[0] = 32'h5A;
    exp_w.push_back({1'b1, 32'h5A});
    exp_aw.push_back({2'b00, 8'd0, 32'h8});
    exp_done.push_back(2'b01);
    issue_cmd(1, 32'h8, 8'd0, 2'b00);
    send_w(1, 5);
    wait_idle();
    repeat (3) step();
    check("t3_done_pulses", done_cnt - d0, 64'd1);
    check("t3_aw_stall_cycles", aw_stall_cnt - s0, 64'd3);
    aw_delay = 0;
    bresp_val = 2'b00;

    // 4: read len=2 with rlast early on beat 2
    rlast_force = 1;
    exp_ar.push_back({2'b10, 8'd2, 32'h0});
    exp_rd.push_back({1'b0, 32'h11});
    exp_rd.push_back({1'b0, 32'h22});
    exp_rd.push_back({1'b1, 32'h33});
    exp_done.push_back(2'b10);
    issue_cmd(0, 32'h0, 8'd2, 2'b10);
    wait_idle();
    rlast_force = -1;

    // 5: read len=7 with rd_ready toggling, EXOKAY on beat 4
    rresp_beat = 3;
    rresp_val = 2'b01;
    for (int i = 0; i < 8; i++) exp_rd.push_back({(i == 7), 32'hA0 + i});
    exp_ar.push_back({2'b01, 8'd7, 32'h10});
    exp_done.push_back(2'b01);
    i_rd_ready = 0;
    issue_cmd(0, 32'h10, 8'd7, 2'b01);
    for (int t = 0; t < 200 && exp_rd.size() != 0; t++) begin
      step();
      i_rd_ready = ~i_rd_ready;
    end
    i_rd_ready = 1;
    wait_idle();
    rresp_beat = -1;
    rresp_val = 2'b00;

    // 6: reset in the middle of a write burst, then a clean read
    d0 = done_cnt;
    wbuf[0] = 32'hC0;
    wbuf[1] = 32'hC1;
    exp_aw.push_back({2'b01, 8'd3, 32'h20});
    exp_w.push_back({1'b0, 32'hC0});
    exp_w.push_back({1'b0, 32'hC1});
    issue_cmd(1, 32'h20, 8'd3, 2'b01);
    send_w(2, 0);
    i_wr_valid = 1;
    i_wr_data = 32'hC2;
    #2 rst = 1;
    #1;
    check("t6_rst_valids", {o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready, o_rd_valid, o_wr_ready}, 64'd0);
    check("t6_rst_busy", o_busy, 64'd0);
    check("t6_rst_cmd_ready", o_cmd_ready, 64'd1);
    check("t6_rst_done", o_done, 64'd0);
    i_wr_valid = 0;
    repeat (2) step();
    rst = 0;
    repeat (3) step();
    check("t6_no_done", done_cnt - d0, 64'd0);
    check("t6_beats_before_rst", exp_w.size(), 64'd0);
    exp_ar.push_back({2'b01, 8'd1, 32'h10});
    exp_rd.push_back({1'b0, 32'hA0});
    exp_rd.push_back({1'b1, 32'hA1});
    exp_done.push_back(2'b00);
    issue_cmd(0, 32'h10, 8'd1, 2'b01);
    wait_idle();
    check("t6_done_after_rst", done_cnt - d0, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
